// File: rtl/mc_ctrl_if.sv
// Control/memory bundle between mc_ctrl and the RV32I datapath plus shared memory port.
// master = sequencer side, slave = datapath/memory side.
interface mc_ctrl_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] instr;
    logic             mem_ready;
    logic             br_taken;
    logic             mem_req;
    logic             mem_we;
    logic             ir_we;
    logic             pc_we;
    logic [1:0]       pc_src;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             reg_we;
    logic [1:0]       wb_sel;
    logic             illegal;
    logic [2:0]       state;

    modport master (
        input  instr, mem_ready, br_taken,
        output mem_req, mem_we, ir_we, pc_we, pc_src, alu_src_a, alu_src_b,
               alu_op, reg_we, wb_sel, illegal, state
    );

    modport slave (
        output instr, mem_ready, br_taken,
        input  mem_req, mem_we, ir_we, pc_we, pc_src, alu_src_a, alu_src_b,
               alu_op, reg_we, wb_sel, illegal, state
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I control sequencer (fetch/decode/exec/mem/wb) over a shared memory port.
// Define MC_CTRL_PERF_EN to add cycle_cnt / instret_cnt performance counters.
module mc_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    mc_ctrl_if.master        bus
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [WIDTH-1:0] cycle_cnt,
    output logic [WIDTH-1:0] instret_cnt
`endif
);
    localparam logic [2:0] S_START  = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd7;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_we;
        logic [1:0] wb_sel;
        logic       illegal;
    } ctrl_t;

    logic [2:0] state_q;
    logic [2:0] state_d;
    ctrl_t      ctl;
    logic [6:0] opc;
    logic       is_legal;
    logic       unused_instr_hi;

    assign opc             = bus.instr[6:0];
    assign unused_instr_hi = ^bus.instr[WIDTH-1:7];

    always_comb begin
        is_legal = 1'b0;
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP: is_legal = 1'b1;
            default:                                is_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_START;
        else     state_q <= state_d;
    end

    always_comb begin
        ctl     = '0;
        state_d = state_q;
        case (state_q)
            S_START: state_d = S_FETCH;
            S_FETCH: begin
                ctl.mem_req = 1'b1;
                if (bus.mem_ready) begin
                    ctl.ir_we = 1'b1;
                    ctl.pc_we = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                if (opc == OPC_FENCE) state_d = S_FETCH;
                else if (is_legal)    state_d = S_EXEC;
                else                  state_d = S_TRAP;
            end
            S_EXEC: begin
                case (opc)
                    OPC_OP: begin
                        ctl.alu_op = 2'b10;
                        state_d    = S_WB;
                    end
                    OPC_OPIMM: begin
                        ctl.alu_src_b = 2'd1;
                        ctl.alu_op    = 2'b10;
                        state_d       = S_WB;
                    end
                    OPC_LOAD, OPC_STORE: begin
                        ctl.alu_src_b = 2'd1;
                        state_d       = S_MEM;
                    end
                    OPC_BRANCH: begin
                        ctl.alu_op = 2'b01;
                        // Branch target is old_pc+imm, computed beside the ALU.
                        if (bus.br_taken) begin
                            ctl.pc_we  = 1'b1;
                            ctl.pc_src = 2'd1;
                        end
                        state_d = S_FETCH;
                    end
                    OPC_JALR: begin
                        ctl.alu_src_b = 2'd1;
                        state_d       = S_WB;
                    end
                    OPC_AUIPC: begin
                        ctl.alu_src_a = 1'b1;
                        ctl.alu_src_b = 2'd1;
                        state_d       = S_WB;
                    end
                    OPC_JAL, OPC_LUI: state_d = S_WB;
                    default:          state_d = S_TRAP;
                endcase
            end
            S_MEM: begin
                ctl.mem_req = 1'b1;
                ctl.mem_we  = (opc == OPC_STORE);
                if (bus.mem_ready) state_d = (opc == OPC_STORE) ? S_FETCH : S_WB;
            end
            S_WB: begin
                ctl.reg_we = 1'b1;
                state_d    = S_FETCH;
                case (opc)
                    OPC_OP, OPC_OPIMM, OPC_AUIPC: ctl.wb_sel = 2'd0;
                    OPC_LOAD:                     ctl.wb_sel = 2'd1;
                    OPC_JAL: begin
                        ctl.wb_sel = 2'd2;
                        ctl.pc_we  = 1'b1;
                        ctl.pc_src = 2'd1;
                    end
                    OPC_JALR: begin
                        ctl.wb_sel = 2'd2;
                        ctl.pc_we  = 1'b1;
                        ctl.pc_src = 2'd2;
                    end
                    OPC_LUI:  ctl.wb_sel = 2'd3;
                    default: begin
                        ctl.reg_we = 1'b0;
                        state_d    = S_TRAP;
                    end
                endcase
            end
            S_TRAP:  ctl.illegal = 1'b1;
            default: state_d = S_START;
        endcase
        // Outputs drop in the same cycle rst rises, so a pending store never completes.
        if (rst) begin
            ctl     = '0;
            state_d = S_START;
        end
    end

    assign bus.mem_req   = ctl.mem_req;
    assign bus.mem_we    = ctl.mem_we;
    assign bus.ir_we     = ctl.ir_we;
    assign bus.pc_we     = ctl.pc_we;
    assign bus.pc_src    = ctl.pc_src;
    assign bus.alu_src_a = ctl.alu_src_a;
    assign bus.alu_src_b = ctl.alu_src_b;
    assign bus.alu_op    = ctl.alu_op;
    assign bus.reg_we    = ctl.reg_we;
    assign bus.wb_sel    = ctl.wb_sel;
    assign bus.illegal   = ctl.illegal;
    assign bus.state     = state_q;

`ifdef MC_CTRL_PERF_EN
    logic retire;
    assign retire = (state_d == S_FETCH) &&
                    (state_q == S_DECODE || state_q == S_EXEC ||
                     state_q == S_MEM    || state_q == S_WB);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (state_q != S_START && state_q != S_TRAP) cycle_cnt <= cycle_cnt + 1'b1;
            if (retire) instret_cnt <= instret_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized self-checking bench for mc_ctrl: each instruction class is walked through
// its phase route, and per-cycle state/controls are compared with a table-driven model.
module tb_mc_ctrl;
    localparam int C_OP = 0, C_OPI = 1, C_LOAD = 2, C_STORE = 3, C_BR = 4, C_JAL = 5,
                   C_JALR = 6, C_AUIPC = 7, C_LUI = 8, C_FENCE = 9, C_ILL = 10;
    localparam int P_S = 0, P_F = 1, P_D = 2, P_E = 3, P_M = 4, P_W = 5, P_T = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_cyc = 0;
    int   exp_ret = 0;

    mc_ctrl_if #(.WIDTH(32)) bus ();

`ifdef MC_CTRL_PERF_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;
`endif

    mc_ctrl #(.WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef MC_CTRL_PERF_EN
        ,
        .cycle_cnt(cycle_cnt),
        .instret_cnt(instret_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [14:0] obs;
    assign obs = {bus.mem_req, bus.mem_we, bus.ir_we, bus.pc_we, bus.pc_src, bus.alu_src_a,
                  bus.alu_src_b, bus.alu_op, bus.reg_we, bus.wb_sel, bus.illegal};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] op_of(input int cls);
        case (cls)
            C_OP:    return 7'b0110011;
            C_OPI:   return 7'b0010011;
            C_LOAD:  return 7'b0000011;
            C_STORE: return 7'b0100011;
            C_BR:    return 7'b1100011;
            C_JAL:   return 7'b1101111;
            C_JALR:  return 7'b1100111;
            C_AUIPC: return 7'b0010111;
            C_LUI:   return 7'b0110111;
            C_FENCE: return 7'b0001111;
            default: return 7'b1110011;
        endcase
    endfunction

    function automatic string cname(input int cls);
        case (cls)
            C_OP:    return "OP";
            C_OPI:   return "OPI";
            C_LOAD:  return "LOAD";
            C_STORE: return "STORE";
            C_BR:    return "BR";
            C_JAL:   return "JAL";
            C_JALR:  return "JALR";
            C_AUIPC: return "AUIPC";
            C_LUI:   return "LUI";
            C_FENCE: return "FENCE";
            default: return "ILL";
        endcase
    endfunction

    // Expected controls for one cycle, straight from the per-state output table.
    function automatic logic [14:0] exp_out(input int p, input int cls, input logic rdy,
                                            input logic br);
        logic       mreq, mwe, irwe, pcwe, asa, rwe, ill;
        logic [1:0] pcsrc, asb, aop, wbs;
        {mreq, mwe, irwe, pcwe, asa, rwe, ill} = '0;
        pcsrc = 2'd0; asb = 2'd0; aop = 2'd0; wbs = 2'd0;
        case (p)
            P_F: begin
                mreq = 1'b1;
                if (rdy) begin irwe = 1'b1; pcwe = 1'b1; end
            end
            P_E: begin
                case (cls)
                    C_OP:                    aop = 2'b10;
                    C_OPI:           begin asb = 2'd1; aop = 2'b10; end
                    C_LOAD, C_STORE, C_JALR: asb = 2'd1;
                    C_AUIPC:         begin asa = 1'b1; asb = 2'd1; end
                    C_BR: begin
                        aop = 2'b01;
                        if (br) begin pcwe = 1'b1; pcsrc = 2'd1; end
                    end
                    default: ;
                endcase
            end
            P_M: begin mreq = 1'b1; mwe = (cls == C_STORE); end
            P_W: begin
                rwe = 1'b1;
                case (cls)
                    C_LOAD:  wbs = 2'd1;
                    C_JAL:   begin wbs = 2'd2; pcwe = 1'b1; pcsrc = 2'd1; end
                    C_JALR:  begin wbs = 2'd2; pcwe = 1'b1; pcsrc = 2'd2; end
                    C_LUI:   wbs = 2'd3;
                    default: wbs = 2'd0;
                endcase
            end
            P_T: ill = 1'b1;
            default: ;
        endcase
        return {mreq, mwe, irwe, pcwe, pcsrc, asa, asb, aop, rwe, wbs, ill};
    endfunction

    task automatic cyc(input int p, input int cls, input logic [31:0] iw, input logic rdy,
                       input logic br, input string tag);
        @(negedge clk);
        bus.instr     = iw;
        bus.mem_ready = rdy;
        bus.br_taken  = br;
        #1;
        chk({tag, ".state"}, 32'(bus.state), 32'(p));
        chk({tag, ".ctl"}, 32'(obs), 32'(exp_out(p, cls, rdy, br)));
`ifdef MC_CTRL_PERF_EN
        chk({tag, ".cyc"}, cycle_cnt, 32'(exp_cyc));
        chk({tag, ".ret"}, instret_cnt, 32'(exp_ret));
`endif
        if (p != P_S && p != P_T) exp_cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        bus.mem_ready = 1'($urandom_range(0, 1));
        bus.br_taken  = 1'($urandom_range(0, 1));
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("rst.state", 32'(bus.state), 32'd0);
            chk("rst.ctl", 32'(obs), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("start.state", 32'(bus.state), 32'd0);
        chk("start.ctl", 32'(obs), 32'd0);
        exp_cyc = 0;
        exp_ret = 0;
`ifdef MC_CTRL_PERF_EN
        chk("start.cyc", cycle_cnt, 32'd0);
        chk("start.ret", instret_cnt, 32'd0);
`endif
    endtask

    // Walk the class's phase route; FETCH/MEM repeat for the given number of wait cycles.
    task automatic run_instr(input int cls, input logic [31:0] iw, input int fw, input int mw,
                             input logic br_in);
        int   rt[5];
        int   n;
        int   reps;
        logic rdy;
        logic br;
        case (cls)
            C_LOAD:  begin rt = '{P_F, P_D, P_E, P_M, P_W}; n = 5; end
            C_STORE: begin rt = '{P_F, P_D, P_E, P_M, 0};   n = 4; end
            C_BR:    begin rt = '{P_F, P_D, P_E, 0, 0};     n = 3; end
            C_FENCE: begin rt = '{P_F, P_D, 0, 0, 0};       n = 2; end
            C_ILL:   begin rt = '{P_F, P_D, P_T, 0, 0};     n = 3; end
            default: begin rt = '{P_F, P_D, P_E, P_W, 0};   n = 4; end
        endcase
        for (int i = 0; i < n; i++) begin
            reps = (rt[i] == P_F) ? fw + 1 : (rt[i] == P_M) ? mw + 1 : 1;
            for (int r = 0; r < reps; r++) begin
                rdy = (rt[i] == P_F || rt[i] == P_M) ? (r == reps - 1)
                                                     : 1'($urandom_range(0, 1));
                br  = (rt[i] == P_E && cls == C_BR) ? br_in : 1'($urandom_range(0, 1));
                cyc(rt[i], cls, iw, rdy, br, $sformatf("%s.p%0d", cname(cls), rt[i]));
            end
        end
        if (cls != C_ILL) exp_ret++;
    endtask

    task automatic trap_hold(input logic [31:0] iw, input int cycles);
        for (int i = 0; i < cycles; i++)
            cyc(P_T, C_ILL, iw, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "trap");
    endtask

    logic [6:0]  ill_tab[4] = '{7'h73, 7'h00, 7'h7f, 7'h0b};
    logic [31:0] rw;
    logic [31:0] iw;
    int          cls;

    initial begin
        bus.instr     = 32'h0;
        bus.mem_ready = 1'b0;
        bus.br_taken  = 1'b0;
        do_reset();

        run_instr(C_OPI, 32'h00500093, 0, 0, 1'b0);
        run_instr(C_LOAD, 32'h0000A103, 0, 3, 1'b0);
        run_instr(C_BR, 32'h00208463, 0, 0, 1'b1);
        run_instr(C_BR, 32'h00208463, 1, 0, 1'b0);
        run_instr(C_JALR, 32'h000080E7, 0, 0, 1'b0);
        run_instr(C_STORE, 32'h00112223, 2, 2, 1'b0);
        run_instr(C_FENCE, 32'h0FF0000F, 0, 0, 1'b0);
        run_instr(C_ILL, 32'h00000073, 0, 0, 1'b0);
        trap_hold(32'h00000073, 12);
        do_reset();

        // Reset while a STORE waits in MEM: request and write must vanish immediately.
        iw = {25'h0, op_of(C_STORE)};
        cyc(P_F, C_STORE, iw, 1'b1, 1'b0, "rstmem.f");
        cyc(P_D, C_STORE, iw, 1'b0, 1'b0, "rstmem.d");
        cyc(P_E, C_STORE, iw, 1'b0, 1'b0, "rstmem.e");
        cyc(P_M, C_STORE, iw, 1'b0, 1'b0, "rstmem.m");
        #2;
        rst = 1'b1;
        #1;
        chk("rstmem.state", 32'(bus.state), 32'd0);
        chk("rstmem.req", 32'(bus.mem_req), 32'd0);
        chk("rstmem.we", 32'(bus.mem_we), 32'd0);
        chk("rstmem.ctl", 32'(obs), 32'd0);
`ifdef MC_CTRL_PERF_EN
        chk("rstmem.ret", instret_cnt, 32'd0);
        chk("rstmem.cyc", cycle_cnt, 32'd0);
`endif
        do_reset();

        for (int k = 0; k < 80; k++) begin
            cls = $urandom_range(0, 10);
            rw  = $urandom;
            iw  = {rw[31:7], (cls == C_ILL) ? ill_tab[$urandom_range(0, 3)] : op_of(cls)};
            run_instr(cls, iw, $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)));
            if (cls == C_ILL) begin
                trap_hold(iw, $urandom_range(1, 4));
                do_reset();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
